rptr_empty_fwft: RTL and testbench

Read-side pointer, empty-flag and first-word-fall-through (FWFT) output stage of the asynchronous FIFO. It is the read-domain counterpart of the write-pointer/full block. It consumes that block's Gray write pointer through an internal two-flop synchronizer and produces the Gray read pointer that the write side synchronizes back. It drives the FIFO memory read address, prefetches the head entry into an output register, and presents it on a valid/ready interface with an occupancy count and an almost-empty flag.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/sync_w2r.sv | 29 ++
 rtl/rptr_empty_fwft.sv | 80 ++++++++
 tb/tb_rptr_empty_fwft.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared async-FIFO constants and Gray/binary conversion helpers.
// Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int c_ADDRSIZE = 4;
    localparam int c_DSIZE    = 8;

    // Inputs are zero-extended to 32 bits, so both helpers serve any pointer
    // width up to 32; callers cast the result back to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_w2r.sv
`default_nettype none
// ============================================================================
// Module      : sync_w2r
// Description : Two-flop synchronizer bringing the Gray write pointer into rclk.
// Revision    : 1.0  initial release
// ============================================================================
module sync_w2r #(
    parameter int WIDTH = 5
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [WIDTH-1:0] wptr,
    output logic [WIDTH-1:0] rq2_wptr
);

    logic [WIDTH-1:0] r_rq1_wptr;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rq1_wptr <= '0;
            rq2_wptr   <= '0;
        end else begin
            r_rq1_wptr <= wptr;
            rq2_wptr   <= r_rq1_wptr;
        end
    end

endmodule : sync_w2r
`default_nettype wire

// File: rtl/rptr_empty_fwft.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_fwft
// Description : Async-FIFO read pointer, empty flag and FWFT output register.
// Revision    : 1.0  initial release
// ============================================================================
module rptr_empty_fwft
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE      = c_ADDRSIZE,
    parameter int DSIZE         = c_DSIZE,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [DSIZE-1:0]    rmem_data,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DSIZE-1:0]    rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic [ADDRSIZE:0]   rcount,
    output logic                raempty
);

    localparam int                c_PTRW      = ADDRSIZE + 1;
    localparam logic [ADDRSIZE+1:0] c_AE_THRESH = (ADDRSIZE+2)'(AEMPTY_THRESH);

    logic [c_PTRW-1:0]  w_rq2_wptr;
    logic [c_PTRW-1:0]  w_rq2_wbin;
    logic [c_PTRW-1:0]  r_rbin;
    logic [c_PTRW-1:0]  w_rbinnext;
    logic [c_PTRW-1:0]  w_rgraynext;
    logic               w_rinc;
    logic [ADDRSIZE+1:0] w_avail;

    sync_w2r #(
        .WIDTH    (c_PTRW)
    ) u_sync_w2r (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .wptr     (wptr),
        .rq2_wptr (w_rq2_wptr)
    );

    // Fetch whenever memory has an entry and the output register is free or
    // being drained this cycle.
    assign w_rinc      = ~rempty & (~rvalid | rready);
    assign w_rbinnext  = r_rbin + {{ADDRSIZE{1'b0}}, w_rinc};
    assign w_rgraynext = c_PTRW'(bin2gray(32'(w_rbinnext)));

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            r_rbin <= w_rbinnext;
            rptr   <= w_rgraynext;
            // Comparing the next pointer keeps fetches from overrunning writes.
            rempty <= (w_rgraynext == w_rq2_wptr);
            rvalid <= w_rinc | (rvalid & ~rready);
            if (w_rinc) begin
                rdata <= rmem_data;
            end
        end
    end

    assign raddr      = r_rbin[ADDRSIZE-1:0];
    assign w_rq2_wbin = c_PTRW'(gray2bin(32'(w_rq2_wptr)));
    assign rcount     = w_rq2_wbin - r_rbin;
    assign w_avail    = {1'b0, rcount} + {{(ADDRSIZE+1){1'b0}}, rvalid};
    assign raempty    = (w_avail <= c_AE_THRESH);

endmodule : rptr_empty_fwft
`default_nettype wire

// File: tb/tb_rptr_empty_fwft.sv
`default_nettype none
// ============================================================================
// Module      : tb_rptr_empty_fwft
// Description : Scoreboard bench for the FWFT read-side pointer/empty block.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rptr_empty_fwft;

    localparam int ADDRSIZE = 4;
    localparam int DSIZE    = 8;

    logic                rclk;
    logic                rrst_n;
    logic [ADDRSIZE:0]   wptr;
    logic [DSIZE-1:0]    rmem_data;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic [DSIZE-1:0]    rdata;
    logic                rvalid;
    logic                rready;
    logic [ADDRSIZE:0]   rcount;
    logic                raempty;

    logic [DSIZE-1:0] mem [16];
    logic [DSIZE-1:0] exp_q [$];
    logic [ADDRSIZE:0] wbin;
    int n_total    = 0;
    int n_pass     = 0;
    int n_popped   = 0;
    int pop_base   = 0;
    int wr_since_rst = 0;

    rptr_empty_fwft #(
        .ADDRSIZE      (ADDRSIZE),
        .DSIZE         (DSIZE),
        .AEMPTY_THRESH (2)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .wptr      (wptr),
        .rmem_data (rmem_data),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rcount    (rcount),
        .raempty   (raempty)
    );

    assign rmem_data = mem[raddr];

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    function automatic logic [ADDRSIZE:0] gray(input logic [ADDRSIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic write_word(input logic [DSIZE-1:0] d);
        mem[wbin[ADDRSIZE-1:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 1'b1;
        wptr = gray(wbin);
        wr_since_rst++;
    endtask

    // Monitor: a word is consumed at the edge following a negedge with rvalid & rready.
    always @(negedge rclk) begin
        if (rrst_n && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got %0h expected none", rdata);
            end else begin
                chk("rdata_order", rdata, exp_q.pop_front());
            end
            n_popped++;
        end
    end

    initial begin
        int cyc;
        int wr;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rrst_n = 1'b0;
        rready = 1'b0;
        wbin   = '0;
        wptr   = '0;
        tick(3);
        chk("rst_rempty",  rempty,  1);
        chk("rst_rvalid",  rvalid,  0);
        chk("rst_rptr",    rptr,    0);
        chk("rst_raddr",   raddr,   0);
        chk("rst_rcount",  rcount,  0);
        chk("rst_raempty", raempty, 1);
        rrst_n = 1'b1;
        tick(1);

        // Single word: first-word latency of four edges.
        write_word(8'hA5);
        tick(2);
        chk("sw_e2_rempty", rempty, 1);
        chk("sw_e2_rvalid", rvalid, 0);
        tick(1);
        chk("sw_e3_rempty", rempty, 0);
        chk("sw_e3_rvalid", rvalid, 0);
        tick(1);
        chk("sw_e4_rvalid",  rvalid,  1);
        chk("sw_e4_rdata",   rdata,   8'hA5);
        chk("sw_e4_rempty",  rempty,  1);
        chk("sw_e4_rptr",    rptr,    5'b00001);
        chk("sw_e4_rcount",  rcount,  0);
        chk("sw_e4_raempty", raempty, 1);
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
        chk("sw_consumed_rvalid", rvalid, 0);

        // Reset mid-stream with a word held in the output register.
        write_word(8'h11);
        write_word(8'h22);
        tick(5);
        chk("pre_rst_rvalid", rvalid, 1);
        rrst_n = 1'b0;
        #1;
        chk("mid_rst_rempty",  rempty,  1);
        chk("mid_rst_rvalid",  rvalid,  0);
        chk("mid_rst_rptr",    rptr,    0);
        chk("mid_rst_rcount",  rcount,  0);
        chk("mid_rst_raempty", raempty, 1);
        exp_q.delete();
        wbin = '0;
        wptr = '0;
        wr_since_rst = 0;
        pop_base = n_popped;
        tick(2);
        rrst_n = 1'b1;
        tick(1);

        // Streaming drain of a full memory.
        for (int i = 0; i < 16; i++) write_word(DSIZE'(i));
        tick(3);
        chk("st_rempty",  rempty,  0);
        chk("st_rcount",  rcount,  16);
        chk("st_raempty", raempty, 0);
        tick(1);
        chk("st_first_rvalid", rvalid, 1);
        chk("st_first_rcount", rcount, 15);
        rready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("st_rvalid_cont", rvalid, 1);
            chk("st_rcount_dn",   rcount, 15 - j);
            tick(1);
        end
        rready = 1'b0;
        chk("st_end_rvalid", rvalid, 0);
        chk("st_end_rptr",   rptr,   5'b11000);
        chk("st_end_rcount", rcount, 0);
        chk("st_end_rempty", rempty, 1);

        // Back-pressure: one fetch, then hold.
        write_word(8'h30);
        write_word(8'h31);
        write_word(8'h32);
        tick(4);
        chk("bp_rvalid", rvalid, 1);
        tick(3);
        chk("bp_rcount", rcount, 2);
        chk("bp_rdata",  rdata,  8'h30);
        chk("bp_raddr",  raddr,  1);
        chk("bp_rptr",   rptr,   5'b11001);
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
        chk("bp_next_rdata",  rdata,  8'h31);
        chk("bp_next_rcount", rcount, 1);
        chk("bp_next_rvalid", rvalid, 1);

        // Almost-empty counts the held word: available 2, then 4, 3, 2.
        chk("ae_avail2_pre", raempty, 1);
        write_word(8'h33);
        write_word(8'h34);
        tick(3);
        chk("ae_avail4_rcount", rcount, 3);
        chk("ae_avail4", raempty, 0);
        rready = 1'b1;
        tick(1);
        chk("ae_avail3", raempty, 0);
        tick(1);
        chk("ae_avail2", raempty, 1);
        tick(3);
        rready = 1'b0;
        chk("ae_drain_rvalid", rvalid, 0);
        chk("ae_drain_rempty", rempty, 1);

        // Wrap-around: 40 entries with irregular consumer back-pressure.
        cyc = 0;
        wr  = 0;
        while ((wr < 40 || exp_q.size() != 0) && cyc < 2000) begin
            if (wr < 40 && (wr_since_rst - (n_popped - pop_base)) < 16) begin
                write_word(8'h40 + DSIZE'(wr));
                wr++;
            end
            rready = (wr == 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick(1);
            chk("wrap_rcount_le16", (rcount <= 16), 1);
            cyc++;
        end
        if (cyc >= 2000) begin
            n_total++;
            $display("FAIL wrap_timeout: got %0d words pending expected 0", exp_q.size());
        end
        tick(2);
        rready = 1'b0;
        chk("wrap_q_empty", exp_q.size(), 0);
        chk("wrap_rvalid",  rvalid, 0);
        chk("wrap_rempty",  rempty, 1);
        chk("wrap_rptr",    rptr,   gray(wbin));
        chk("wrap_rcount",  rcount, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rptr_empty_fwft
`default_nettype wire
